// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch PC unit.
// Provides pc_t, the next-PC source enum, RESET_PC and a sign-extender.
package fetch_pkg;

    localparam int unsigned PC_W_DEF = 12;
    localparam int unsigned RESET_PC = 0;

    typedef logic [PC_W_DEF-1:0] pc_t;

    typedef enum logic [2:0] {
        PLUS1,
        HOLD,
        OFFSET,
        CONST,
        STACK,
        TRAP
    } pc_src_e;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext(
        input logic [31:0] v,
        input int unsigned w
    );
        logic signed [31:0] t;
        t = signed'(v << (32 - w));
        return unsigned'(t >>> (32 - w));
    endfunction

endpackage

// File: rtl/fetch_pc_unit_return_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
// Ports: clk, rst (async active-low), push, pop, push_data in;
//        top, empty, full, ovf, udf out.
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign wr_idx  = AW'(sp);
    assign top_idx = AW'(sp - SPW'(1));
    assign empty   = (sp == '0);
    assign full    = (sp == SPW'(DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Call+return together replaces the top in place; on an empty
            // stack it falls through to a plain push.
            if (push && pop && !empty) begin
                mem[top_idx] <= push_data;
            end else if (push && !full) begin
                mem[wr_idx] <= push_data;
                sp          <= sp + SPW'(1);
            end else if (pop && !push && !empty) begin
                sp <= sp - SPW'(1);
            end
            if (push && !pop && full) begin
                ovf <= 1'b1;
            end
            if (pop && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: PC register, next-PC mux, return stack and flush generation.
// Ports: clk, rst (async active-low), stall, sel_PC_src_{offset,const,stack},
//   push_stack, pop_stack, ex_pc, ex_offset, ex_const in; imem_addr,
//   pc_plus1, flush, stack_ovf, stack_udf out; trap out when PC_TRAP_EN.
// Optional: define PC_TRAP_EN to vector stack faults to TRAP_ADDR.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = 12,
    parameter int                  OFFSET_WIDTH = 8,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] TRAP_ADDR    = 12'hFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    sel_PC_src_offset,
    input  logic                    sel_PC_src_const,
    input  logic                    sel_PC_src_stack,
    input  logic                    push_stack,
    input  logic                    pop_stack,
    input  logic [PC_WIDTH-1:0]     ex_pc,
    input  logic [OFFSET_WIDTH-1:0] ex_offset,
    input  logic [PC_WIDTH-1:0]     ex_const,
    output logic [PC_WIDTH-1:0]     imem_addr,
    output logic [PC_WIDTH-1:0]     pc_plus1,
    output logic                    flush,
    output logic                    stack_ovf,
    output logic                    stack_udf
`ifdef PC_TRAP_EN
    ,
    output logic                    trap
`endif
);

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] top_val;
    logic [PC_WIDTH-1:0] off_tgt;
    logic [31:0]         off_ext;
    logic                redirect;
    logic                st_empty;
    logic                st_full;
    pc_src_e             src;

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_stack),
        .pop       (pop_stack),
        .push_data (ex_pc + PC_WIDTH'(1)),
        .top       (top_val),
        .empty     (st_empty),
        .full      (st_full),
        .ovf       (stack_ovf),
        .udf       (stack_udf)
    );

    assign imem_addr = pc;
    assign pc_plus1  = pc + PC_WIDTH'(1);
    assign redirect  = sel_PC_src_offset | sel_PC_src_const
                     | sel_PC_src_stack;
    assign off_ext   = sext(32'(ex_offset), OFFSET_WIDTH);
    assign off_tgt   = ex_pc + off_ext[PC_WIDTH-1:0];

`ifdef PC_TRAP_EN
    logic fault;
    assign fault = (push_stack & ~pop_stack & st_full)
                 | (pop_stack & st_empty);
    assign flush = redirect | fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trap <= 1'b0;
        end else begin
            trap <= fault;
        end
    end
`else
    logic unused_stack_state;
    assign unused_stack_state = st_empty ^ st_full;
    assign flush = redirect;
`endif

    // Later assignments win, giving stack > const > offset > stall.
    always_comb begin
        src = PLUS1;
        if (stall)             src = HOLD;
        if (sel_PC_src_offset) src = OFFSET;
        if (sel_PC_src_const)  src = CONST;
        if (sel_PC_src_stack)  src = STACK;
`ifdef PC_TRAP_EN
        if (fault)             src = TRAP;
`endif
    end

    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        unique case (src)
            PLUS1:   pc_next = pc + PC_WIDTH'(1);
            HOLD:    pc_next = pc;
            OFFSET:  pc_next = off_tgt;
            CONST:   pc_next = ex_const;
            STACK:   pc_next = top_val;
            TRAP:    pc_next = TRAP_ADDR;
            default: pc_next = pc + PC_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_WIDTH'(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: random and directed stimulus checked
// against a queue-based reference model of the PC and return stack.
module tb_fetch_pc_unit;
    import fetch_pkg::*;

    localparam int D = 8;
`ifdef PC_TRAP_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, sel_PC_src_offset, sel_PC_src_const;
    logic        sel_PC_src_stack, push_stack, pop_stack;
    logic [11:0] ex_pc, ex_const, imem_addr, pc_plus1;
    logic [7:0]  ex_offset;
    logic        flush, stack_ovf, stack_udf;
    logic        trap_s;

    fetch_pc_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .sel_PC_src_offset (sel_PC_src_offset),
        .sel_PC_src_const  (sel_PC_src_const),
        .sel_PC_src_stack  (sel_PC_src_stack),
        .push_stack        (push_stack),
        .pop_stack         (pop_stack),
        .ex_pc             (ex_pc),
        .ex_offset         (ex_offset),
        .ex_const          (ex_const),
        .imem_addr         (imem_addr),
        .pc_plus1          (pc_plus1),
        .flush             (flush),
        .stack_ovf         (stack_ovf),
        .stack_udf         (stack_udf)
`ifdef PC_TRAP_EN
        ,
        .trap              (trap_s)
`endif
    );

`ifndef PC_TRAP_EN
    assign trap_s = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        pc_t pc;
        bit  ovf;
        bit  udf;
        bit  trap;
    } exp_t;

    exp_t sq[$];
    bit   fq[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_pc;
    int   m_stk[$];
    bit   m_ovf, m_udf, m_trap;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_udf = 0;
        m_trap = 0;
    endtask

    task automatic apply(input bit st, input bit so, input bit sc,
                         input bit ss, input bit pu, input bit po,
                         input logic [11:0] epc, input logic [7:0] off,
                         input logic [11:0] cst);
        int  sz, tos, nxt, ret, e;
        bit  fault;
        stall = st;
        sel_PC_src_offset = so;
        sel_PC_src_const = sc;
        sel_PC_src_stack = ss;
        push_stack = pu;
        pop_stack = po;
        ex_pc = epc;
        ex_offset = off;
        ex_const = cst;
        sz    = m_stk.size();
        tos   = (sz > 0) ? m_stk[sz-1] : 0;
        fault = TE && ((pu && !po && sz == D) || (po && sz == 0));
        fq.push_back(so || sc || ss || fault);
        e = int'(epc);
        if (fault)   nxt = 'hFFF;
        else if (ss) nxt = tos;
        else if (sc) nxt = int'(cst);
        else if (so) nxt = (e + int'($signed(off))) & 'hFFF;
        else if (st) nxt = m_pc;
        else         nxt = (m_pc + 1) & 'hFFF;
        ret = (e + 1) & 'hFFF;
        if (pu && po) begin
            if (sz > 0) m_stk[sz-1] = ret;
            else begin
                m_stk.push_back(ret);
                m_udf = 1;
            end
        end else if (pu) begin
            if (sz < D) m_stk.push_back(ret);
            else m_ovf = 1;
        end else if (po) begin
            if (sz > 0) void'(m_stk.pop_back());
            else m_udf = 1;
        end
        m_trap = fault;
        m_pc = nxt;
        sq.push_back('{pc: 12'(nxt), ovf: m_ovf, udf: m_udf,
                       trap: m_trap});
    endtask

    task automatic cyc(input bit st, input bit so, input bit sc,
                       input bit ss, input bit pu, input bit po,
                       input logic [11:0] epc, input logic [7:0] off,
                       input logic [11:0] cst);
        @(negedge clk);
        apply(st, so, sc, ss, pu, po, epc, off, cst);
    endtask

    // Post-edge state monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && sq.size() > 0) begin
                e = sq.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("pc_plus1", pc_plus1, e.pc + 12'd1);
                chk("stack_ovf", stack_ovf, e.ovf);
                chk("stack_udf", stack_udf, e.udf);
`ifdef PC_TRAP_EN
                chk("trap", trap_s, e.trap);
`endif
            end
        end
    end

    // Same-cycle flush monitor.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (fq.size() > 0) chk("flush", flush, fq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        stall = 0; sel_PC_src_offset = 0; sel_PC_src_const = 0;
        sel_PC_src_stack = 0; push_stack = 0; pop_stack = 0;
        ex_pc = '0; ex_offset = '0; ex_const = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_imem", imem_addr, 12'h000);
        chk("rst_plus1", pc_plus1, 12'h001);
        chk("rst_flush", flush, 1'b0);
        chk("rst_ovf", stack_ovf, 1'b0);
        chk("rst_udf", stack_udf, 1'b0);
        chk("rst_trap", trap_s, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        cyc(0, 0, 1, 0, 0, 0, 0, 0, 12'h005);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 12'h040);
        cyc(0, 1, 0, 0, 0, 0, 12'h010, 8'hFC, 0);
        cyc(0, 1, 0, 0, 0, 0, 12'hFFE, 8'h03, 0);

        cyc(0, 0, 0, 0, 1, 0, 12'h100, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 12'h200, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 12'(12'h2F9 + i), 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0, 12'h500, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 12'h400, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(7) == 0,
                $urandom_range(7) == 0, $urandom_range(7) == 0,
                $urandom_range(4) == 0, $urandom_range(4) == 0,
                12'($urandom), 8'($urandom), 12'($urandom));
        end

        cyc(0, 0, 1, 0, 0, 0, 0, 0, 12'h123);
        #3 rst = 1'b0;
        sq.delete();
        model_reset();
        #1;
        chk("arst_imem", imem_addr, 12'h000);
        chk("arst_plus1", pc_plus1, 12'h001);
        chk("arst_ovf", stack_ovf, 1'b0);
        chk("arst_udf", stack_udf, 1'b0);
        chk("arst_trap", trap_s, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        apply(0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc($urandom_range(3) == 0, $urandom_range(7) == 0,
                $urandom_range(7) == 0, $urandom_range(7) == 0,
                $urandom_range(3) == 0, $urandom_range(4) == 0,
                12'($urandom), 8'($urandom), 12'($urandom));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
